// File: rtl/fp_add_pipe.sv
// Three-stage pipelined IEEE-754 adder/subtractor with a valid/ready stream on each side.
// S1 unpacks the operands and aligns them, S2 adds and normalises, and S3 rounds, packs and drives the outputs.
// NaN and Inf results are decided in S1 and ride the pipe as an override of the arithmetic result.
module fp_add_pipe #(
    parameter int EXP_W = 5,
    parameter int MAN_W = 10,
    parameter int TAG_W = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [EXP_W+MAN_W:0]   in_a,
    input  logic [EXP_W+MAN_W:0]   in_b,
    input  logic                   in_sub,
    input  logic [TAG_W-1:0]       in_tag,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [EXP_W+MAN_W:0]   out_sum,
    output logic [TAG_W-1:0]       out_tag,
    output logic [3:0]             out_flags
);
    localparam int W  = EXP_W + MAN_W + 1;
    localparam int MW = MAN_W + 4;                  // hidden, frac, guard, round, sticky
    localparam logic [EXP_W-1:0] EXP_ONES = '1;
    localparam logic [W-1:0] QNAN = {1'b0, EXP_ONES, 1'b1, {(MAN_W-1){1'b0}}};

    // stage valids, handshake and pipeline registers
    logic s1_valid_q, s1_valid_d, s2_valid_q, s2_valid_d, out_valid_q, out_valid_d;
    logic ready1, ready2, ready3, load1, load2, load3;

    logic             s1_sign_q, s1_sign_d, s1_eff_sub_q, s1_eff_sub_d;
    logic [EXP_W-1:0] s1_exp_q, s1_exp_d;
    logic [MW-1:0]    s1_big_q, s1_big_d, s1_sml_q, s1_sml_d;
    logic             s1_spec_q, s1_spec_d, s1_inv_q, s1_inv_d;
    logic [W-1:0]     s1_spec_val_q, s1_spec_val_d;
    logic [TAG_W-1:0] s1_tag_q, s1_tag_d;

    logic             s2_sign_q, s2_sign_d;
    logic [EXP_W:0]   s2_exp_q, s2_exp_d;
    logic [MW-1:0]    s2_m_q, s2_m_d;
    logic             s2_spec_q, s2_spec_d, s2_inv_q, s2_inv_d;
    logic [W-1:0]     s2_spec_val_q, s2_spec_val_d;
    logic [TAG_W-1:0] s2_tag_q, s2_tag_d;

    logic [W-1:0]     out_sum_q, out_sum_d;
    logic [TAG_W-1:0] out_tag_q, out_tag_d;
    logic [3:0]       out_flags_q, out_flags_d;

    // each stage can take new data when it is empty or is draining this cycle
    always_comb begin
        ready3      = !out_valid_q || out_ready;
        ready2      = !s2_valid_q || ready3;
        ready1      = !s1_valid_q || ready2;
        load1       = in_valid && ready1;
        load2       = s1_valid_q && ready2;
        load3       = s2_valid_q && ready3;
        s1_valid_d  = ready1 ? in_valid : s1_valid_q;
        s2_valid_d  = ready2 ? s1_valid_q : s2_valid_q;
        out_valid_d = ready3 ? s2_valid_q : out_valid_q;
    end

    assign in_ready  = ready1;
    assign out_valid = out_valid_q;
    assign out_sum   = out_sum_q;
    assign out_tag   = out_tag_q;
    assign out_flags = out_flags_q;

    // S1: classify the operands, swap so the larger magnitude is first, and align the smaller one
    logic             a_sign, b_sign, a_nan, b_nan, a_inf, b_inf, a_snan, b_snan, a_big, inf_clash;
    logic [EXP_W-1:0] a_exp, b_exp, a_eexp, b_eexp, sml_e, diff;
    logic [MAN_W-1:0] a_frac, b_frac;
    logic [MAN_W:0]   a_man, b_man, sml_m;
    logic [2*MW-1:0]  sml_wide;
    always_comb begin
        a_sign = in_a[W-1];
        b_sign = in_b[W-1] ^ in_sub;
        a_exp  = in_a[W-2:MAN_W];
        b_exp  = in_b[W-2:MAN_W];
        a_frac = in_a[MAN_W-1:0];
        b_frac = in_b[MAN_W-1:0];
        a_nan  = (a_exp == EXP_ONES) && (a_frac != '0);
        b_nan  = (b_exp == EXP_ONES) && (b_frac != '0);
        a_inf  = (a_exp == EXP_ONES) && (a_frac == '0);
        b_inf  = (b_exp == EXP_ONES) && (b_frac == '0);
        a_snan = a_nan && !a_frac[MAN_W-1];
        b_snan = b_nan && !b_frac[MAN_W-1];
        // subnormals sit at effective exponent 1 with no hidden bit
        a_eexp = (a_exp == '0) ? EXP_W'(1) : a_exp;
        b_eexp = (b_exp == '0) ? EXP_W'(1) : b_exp;
        a_man  = {a_exp != '0, a_frac};
        b_man  = {b_exp != '0, b_frac};
        // raw {exp, frac} orders magnitudes correctly, subnormals included
        a_big  = in_a[W-2:0] >= in_b[W-2:0];

        s1_sign_d    = a_big ? a_sign : b_sign;
        s1_exp_d     = a_big ? a_eexp : b_eexp;
        s1_big_d     = {(a_big ? a_man : b_man), 3'b000};
        sml_e        = a_big ? b_eexp : a_eexp;
        sml_m        = a_big ? b_man : a_man;
        s1_eff_sub_d = a_sign ^ b_sign;
        diff         = s1_exp_d - sml_e;
        // the low half of the wide shift collects every bit that falls off into sticky
        sml_wide     = {sml_m, 3'b000, {MW{1'b0}}} >> diff;
        if (diff >= EXP_W'(MW)) begin
            s1_sml_d = {{(MW-1){1'b0}}, |sml_m};
        end else begin
            s1_sml_d = {sml_wide[2*MW-1:MW+1], sml_wide[MW] | (|sml_wide[MW-1:0])};
        end

        inf_clash = a_inf && b_inf && (a_sign != b_sign);
        s1_spec_d = a_nan || b_nan || a_inf || b_inf;
        s1_inv_d  = a_snan || b_snan || inf_clash;
        if (a_nan || b_nan || inf_clash) begin
            s1_spec_val_d = QNAN;
        end else if (a_inf) begin
            s1_spec_val_d = {a_sign, EXP_ONES, {MAN_W{1'b0}}};
        end else begin
            s1_spec_val_d = {b_sign, EXP_ONES, {MAN_W{1'b0}}};
        end
        s1_tag_d = in_tag;
    end

    // S2: add or subtract the magnitudes, then normalise without dropping below exponent 1
    logic [MW:0]    sum;
    logic [EXP_W:0] lzc, max_sh, sh;
    always_comb begin
        if (s1_eff_sub_q) begin
            sum = {1'b0, s1_big_q} - {1'b0, s1_sml_q};
        end else begin
            sum = {1'b0, s1_big_q} + {1'b0, s1_sml_q};
        end
        lzc = (EXP_W+1)'(MW);
        for (int i = 0; i < MW; i++) begin
            if (sum[i]) lzc = (EXP_W+1)'(MW - 1 - i);
        end
        max_sh = {1'b0, s1_exp_q} - (EXP_W+1)'(1);
        sh     = (lzc < max_sh) ? lzc : max_sh;
        if (sum[MW]) begin
            s2_m_d   = {sum[MW:2], sum[1] | sum[0]};
            s2_exp_d = {1'b0, s1_exp_q} + (EXP_W+1)'(1);
        end else begin
            s2_m_d   = sum[MW-1:0] << sh;
            s2_exp_d = {1'b0, s1_exp_q} - sh;
        end
        // an exact cancellation is +0; zero plus zero of the same sign keeps that sign
        s2_sign_d     = (s1_eff_sub_q && (sum == '0)) ? 1'b0 : s1_sign_q;
        s2_spec_d     = s1_spec_q;
        s2_inv_d      = s1_inv_q;
        s2_spec_val_d = s1_spec_val_q;
        s2_tag_d      = s1_tag_q;
    end

    // S3: round to nearest even, pack, and raise the exception flags
    logic [MAN_W+1:0] rm;
    logic [EXP_W:0]   re;
    logic             inexact, rnd_up, tiny;
    always_comb begin
        inexact = s2_m_q[2] | s2_m_q[1] | s2_m_q[0];
        rnd_up  = s2_m_q[2] & (s2_m_q[1] | s2_m_q[0] | s2_m_q[3]);
        rm      = {1'b0, s2_m_q[MW-1:3]} + (MAN_W+2)'(rnd_up);
        re      = s2_exp_q;
        if (rm[MAN_W+1]) begin
            rm = rm >> 1;
            re = re + (EXP_W+1)'(1);
        end
        // no hidden bit after rounding means the result is subnormal, so the exp field is 0
        tiny        = !rm[MAN_W];
        out_sum_d   = {s2_sign_q, (tiny ? {EXP_W{1'b0}} : re[EXP_W-1:0]), rm[MAN_W-1:0]};
        out_flags_d = {1'b0, 1'b0, tiny && inexact, inexact};
        if (re >= {1'b0, EXP_ONES}) begin
            out_sum_d   = {s2_sign_q, EXP_ONES, {MAN_W{1'b0}}};
            out_flags_d = 4'b0101;
        end
        if (s2_spec_q) begin
            out_sum_d   = s2_spec_val_q;
            out_flags_d = {s2_inv_q, 3'b000};
        end
        out_tag_d = s2_tag_q;
    end

    // control and output registers, cleared by reset
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q  <= 1'b0;
            s2_valid_q  <= 1'b0;
            out_valid_q <= 1'b0;
            out_sum_q   <= '0;
            out_tag_q   <= '0;
            out_flags_q <= '0;
        end else begin
            s1_valid_q  <= s1_valid_d;
            s2_valid_q  <= s2_valid_d;
            out_valid_q <= out_valid_d;
            if (load3) begin
                out_sum_q   <= out_sum_d;
                out_tag_q   <= out_tag_d;
                out_flags_q <= out_flags_d;
            end
        end
    end

    // datapath registers in S1 and S2; they only matter while their stage is valid
    always_ff @(posedge clk) begin
        if (load1) begin
            s1_sign_q     <= s1_sign_d;
            s1_eff_sub_q  <= s1_eff_sub_d;
            s1_exp_q      <= s1_exp_d;
            s1_big_q      <= s1_big_d;
            s1_sml_q      <= s1_sml_d;
            s1_spec_q     <= s1_spec_d;
            s1_inv_q      <= s1_inv_d;
            s1_spec_val_q <= s1_spec_val_d;
            s1_tag_q      <= s1_tag_d;
        end
        if (load2) begin
            s2_sign_q     <= s2_sign_d;
            s2_exp_q      <= s2_exp_d;
            s2_m_q        <= s2_m_d;
            s2_spec_q     <= s2_spec_d;
            s2_inv_q      <= s2_inv_d;
            s2_spec_val_q <= s2_spec_val_d;
            s2_tag_q      <= s2_tag_d;
        end
    end

endmodule
